// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 4-bit write-only sequencer: autonomous power-on init, then byte writes via valid/ready.
// Optional LCD_CMD_FIFO_EN queues up to 4 {rs,data} entries in front of the sequencer.
module lcd_hd44780_ctrl #(
   parameter int POWERON_CYCLES    = 1_080_000,
   parameter int SETUP_CYCLES      = 2,
   parameter int E_CYCLES          = 12,
   parameter int HOLD_CYCLES       = 2,
   parameter int CMD_WAIT_CYCLES   = 1_080,
   parameter int CLEAR_WAIT_CYCLES = 44_280
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_rs,
   input  logic [7:0] cmd_data,
   output logic       init_done,
   output logic       busy,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e,
   output logic [3:0] lcd_db
);
   localparam int NIB_CYCLES = SETUP_CYCLES + E_CYCLES + HOLD_CYCLES;
   localparam int MAX_A = (POWERON_CYCLES > CLEAR_WAIT_CYCLES) ? POWERON_CYCLES : CLEAR_WAIT_CYCLES;
   localparam int MAX_B = (CMD_WAIT_CYCLES > NIB_CYCLES) ? CMD_WAIT_CYCLES : NIB_CYCLES;
   localparam int MAXC  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [CW-1:0] PWR_LAST   = CW'(POWERON_CYCLES - 1);
   localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
   localparam logic [CW-1:0] E_LAST     = CW'(E_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] NIB_LAST   = CW'(NIB_CYCLES - 1);
   localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_WAIT_CYCLES - 1);
   localparam logic [CW-1:0] CLR_LAST   = CW'(CLEAR_WAIT_CYCLES - 1);
   localparam logic [CW-1:0] E_FIRST    = CW'(SETUP_CYCLES);
   localparam logic [CW-1:0] E_END      = CW'(SETUP_CYCLES + E_CYCLES);

   typedef enum logic [3:0] {
      PWRON, INIT_NIB, INIT_WAIT, INIT_BYTE, IDLE, NIB_SETUP, NIB_E, NIB_HOLD, BYTE_WAIT
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    idx, idx_n;       // 0-3: init nibbles, 4-7: init bytes
   logic          low_q, low_n;
   logic [8:0]    byte_q, byte_n;   // {rs, data} of the byte in flight
   logic          done_n, e_n, rs_n;
   logic [3:0]    db_n;
   logic          load, load_rs;
   logic [7:0]    load_data;
   logic          take, take_rs;
   logic [7:0]    take_data;
   logic [CW-1:0] wait_last;

   function automatic logic [7:0] init_byte(input logic [1:0] i);
      case (i)
         2'd0:    init_byte = 8'h28;
         2'd1:    init_byte = 8'h0C;
         2'd2:    init_byte = 8'h01;
         default: init_byte = 8'h06;
      endcase
   endfunction

`ifdef LCD_CMD_FIFO_EN
   logic [8:0] fifo_mem [4];
   logic [1:0] wr_ptr, rd_ptr;
   logic [2:0] fifo_cnt;
   logic       fifo_full, fifo_empty, push;

   assign fifo_full  = (fifo_cnt == 3'd4);
   assign fifo_empty = (fifo_cnt == 3'd0);
   assign cmd_ready  = !fifo_full;
   assign push       = cmd_valid && !fifo_full;
   assign take       = init_done && (state == IDLE) && !fifo_empty;
   assign take_rs    = fifo_mem[rd_ptr][8];
   assign take_data  = fifo_mem[rd_ptr][7:0];
   assign busy       = (state != IDLE) || !fifo_empty;

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr   <= 2'd0;
         rd_ptr   <= 2'd0;
         fifo_cnt <= 3'd0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (take) rd_ptr <= rd_ptr + 2'd1;
         fifo_cnt <= fifo_cnt + {2'b00, push} - {2'b00, take};
      end
   end

   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr] <= {cmd_rs, cmd_data};
   end
`else
   assign cmd_ready = init_done && (state == IDLE);
   assign take      = cmd_valid && cmd_ready;
   assign take_rs   = cmd_rs;
   assign take_data = cmd_data;
   assign busy      = (state != IDLE);
`endif

   // Clear and home need the long settle time; everything else the short one.
   assign wait_last = (!byte_q[8] && (byte_q[7:0] == 8'h01 || byte_q[7:0] == 8'h02)) ? CLR_LAST : CMD_LAST;

   always_comb begin
      state_n   = state;
      cnt_n     = cnt + 1'b1;
      idx_n     = idx;
      low_n     = low_q;
      byte_n    = byte_q;
      done_n    = init_done;
      rs_n      = lcd_rs;
      db_n      = lcd_db;
      load      = 1'b0;
      load_rs   = 1'b0;
      load_data = 8'h00;
      case (state)
         PWRON: if (cnt == PWR_LAST) begin
            state_n = INIT_NIB;
            cnt_n   = '0;
            rs_n    = 1'b0;
            db_n    = 4'h3;
         end
         INIT_NIB: if (cnt == NIB_LAST) begin
            state_n = INIT_WAIT;
            cnt_n   = '0;
         end
         INIT_WAIT: if (cnt == CLR_LAST) begin
            cnt_n = '0;
            if (idx == 3'd3) begin
               idx_n     = 3'd4;
               load      = 1'b1;
               load_data = init_byte(2'd0);
            end else begin
               idx_n   = idx + 3'd1;
               state_n = INIT_NIB;
               db_n    = (idx == 3'd2) ? 4'h2 : 4'h3;
            end
         end
         INIT_BYTE: if (cnt == wait_last) begin
            cnt_n = '0;
            if (idx == 3'd7) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end else begin
               idx_n     = idx + 3'd1;
               load      = 1'b1;
               load_data = init_byte(idx[1:0] + 2'd1);
            end
         end
         NIB_SETUP: if (cnt == SETUP_LAST) begin
            state_n = NIB_E;
            cnt_n   = '0;
         end
         NIB_E: if (cnt == E_LAST) begin
            state_n = NIB_HOLD;
            cnt_n   = '0;
         end
         NIB_HOLD: if (cnt == HOLD_LAST) begin
            cnt_n = '0;
            if (!low_q) begin
               low_n   = 1'b1;
               state_n = NIB_SETUP;
               db_n    = byte_q[3:0];
            end else begin
               state_n = init_done ? BYTE_WAIT : INIT_BYTE;
            end
         end
         BYTE_WAIT: if (cnt == wait_last) begin
            state_n = IDLE;
            cnt_n   = '0;
         end
         IDLE: begin
            cnt_n = '0;
            if (take) begin
               load      = 1'b1;
               load_rs   = take_rs;
               load_data = take_data;
            end
         end
         default: begin
            state_n = PWRON;
            cnt_n   = '0;
         end
      endcase

      if (load) begin
         state_n = NIB_SETUP;
         cnt_n   = '0;
         byte_n  = {load_rs, load_data};
         low_n   = 1'b0;
         rs_n    = load_rs;
         db_n    = load_data[7:4];
      end

      // lcd_e is registered from the next state so it lines up with the state register.
      e_n = (state_n == NIB_E) ||
            (state_n == INIT_NIB && cnt_n >= E_FIRST && cnt_n < E_END);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= PWRON;
         cnt       <= '0;
         idx       <= 3'd0;
         low_q     <= 1'b0;
         byte_q    <= 9'd0;
         init_done <= 1'b0;
         lcd_e     <= 1'b0;
         lcd_rs    <= 1'b0;
         lcd_db    <= 4'h0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         idx       <= idx_n;
         low_q     <= low_n;
         byte_q    <= byte_n;
         init_done <= done_n;
         lcd_e     <= e_n;
         lcd_rs    <= rs_n;
         lcd_db    <= db_n;
      end
   end

   assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Directed + randomized bench for lcd_hd44780_ctrl; expectations come from a byte-level model of the LCD bus.
module tb_lcd_hd44780_ctrl;
   localparam int PON = 100, SU = 1, EW = 2, HO = 1, CMDW = 10, CLR = 50;
   localparam int NIB = SU + EW + HO;
   localparam logic [3:0] INIT_NIBS [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};

   logic       clock = 1'b0;
   logic       reset, cmd_valid, cmd_ready, cmd_rs, init_done, busy;
   logic       lcd_rs, lcd_rw, lcd_e;
   logic [7:0] cmd_data;
   logic [3:0] lcd_db;

   int n_vec = 0;
   int n_err = 0;

   lcd_hd44780_ctrl #(
      .POWERON_CYCLES(PON), .SETUP_CYCLES(SU), .E_CYCLES(EW), .HOLD_CYCLES(HO),
      .CMD_WAIT_CYCLES(CMDW), .CLEAR_WAIT_CYCLES(CLR)
   ) dut (
      .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_rs(cmd_rs), .cmd_data(cmd_data), .init_done(init_done), .busy(busy),
      .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_db(lcd_db)
   );

   always #5 clock = ~clock;

   // Bus monitor: logs each E pulse's {rs,db}, its width, and any rs/db movement around it.
   logic [4:0] obs_q [$];
   int         width_q [$];
   int         stab_bad = 0, rw_bad = 0, hi_cnt = 0;
   logic       last_e = 1'b0, last_rs = 1'b0;
   logic [3:0] last_db = 4'h0;
   logic [4:0] cap = 5'd0;

   always @(negedge clock) begin
      if (lcd_rw !== 1'b0) rw_bad++;
      if (lcd_e && !last_e) begin
         cap = {lcd_rs, lcd_db};
         obs_q.push_back(cap);
         if ({last_rs, last_db} !== cap) stab_bad++;
         hi_cnt = 1;
      end else if (lcd_e) begin
         hi_cnt++;
         if ({lcd_rs, lcd_db} !== cap) stab_bad++;
      end else if (last_e) begin
         width_q.push_back(hi_cnt);
         if ({lcd_rs, lcd_db} !== cap) stab_bad++;
      end
      last_e  = lcd_e;
      last_rs = lcd_rs;
      last_db = lcd_db;
   end

   function automatic int byte_time(input logic rs, input logic [7:0] d);
      return 2 * NIB + ((!rs && (d == 8'h01 || d == 8'h02)) ? CLR : CMDW);
   endfunction

   function automatic int init_time();
      return PON + 4 * (NIB + CLR) + byte_time(1'b0, 8'h28) + byte_time(1'b0, 8'h0C)
             + byte_time(1'b0, 8'h01) + byte_time(1'b0, 8'h06);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_lcd_e", lcd_e, 0);
      check("rst_lcd_rs", lcd_rs, 0);
      check("rst_lcd_rw", lcd_rw, 0);
      check("rst_lcd_db", lcd_db, 0);
      check("rst_init_done", init_done, 0);
      check("rst_busy", busy, 1);
`ifndef LCD_CMD_FIFO_EN
      check("rst_cmd_ready", cmd_ready, 0);
`endif
   endtask

   // Call right after dropping reset on a negedge.
   task automatic check_init();
      int cyc = -1, base = 0, bw = 0, sb = 0, rb = 0, rdy_seen = 0;
      for (int i = 1; i <= 3000; i++) begin
         @(posedge clock); #1;
         if (i == 1) begin
            base = obs_q.size(); bw = width_q.size(); sb = stab_bad; rb = rw_bad;
         end
         if (init_done) begin
            cyc = i;
            break;
         end else if (cmd_ready) rdy_seen++;
      end
      check("init_time_window", (cyc >= init_time() - 1 && cyc <= init_time() + 1), 1);
      check("init_pulses", obs_q.size() - base, 12);
      for (int j = 0; j < 12; j++) begin
         check($sformatf("init_nib%0d", j), obs_q[base + j], {1'b0, INIT_NIBS[j]});
         check($sformatf("init_ewidth%0d", j), width_q[bw + j], EW);
      end
      check("init_db_stable", stab_bad - sb, 0);
      check("init_rw_low", rw_bad - rb, 0);
`ifndef LCD_CMD_FIFO_EN
      check("init_ready_low", rdy_seen, 0);
`endif
   endtask

   task automatic send_byte(input logic rs, input logic [7:0] d, input bit keep);
      bit ok = 0;
      cmd_valid = 1'b1; cmd_rs = rs; cmd_data = d;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clock);
         if (cmd_ready) begin ok = 1; break; end
      end
      check("accept_seen", ok, 1);
      @(posedge clock); #1;
      if (!keep) cmd_valid = 1'b0;
   endtask

   task automatic wait_ready(output int k);
      k = -1;
      for (int i = 1; i <= 3000; i++) begin
         @(posedge clock); #1;
         if (cmd_ready) begin k = i; break; end
      end
   endtask

   task automatic do_byte(input logic rs, input logic [7:0] d);
      int base, bw, sb, k;
      base = obs_q.size(); bw = width_q.size(); sb = stab_bad;
      send_byte(rs, d, 1'b0);
      check("ready_drop", cmd_ready, 0);
      wait_ready(k);
      check($sformatf("latency_rs%0d_%02h", rs, d), k, byte_time(rs, d));
      check("byte_pulses", obs_q.size() - base, 2);
      check("nib_hi", obs_q[base], {rs, d[7:4]});
      check("nib_lo", obs_q[base + 1], {rs, d[3:0]});
      check("ewidth_hi", width_q[bw], EW);
      check("ewidth_lo", width_q[bw + 1], EW);
      check("byte_db_stable", stab_bad - sb, 0);
   endtask

   initial begin
      int         k, base;
      bit         found;
      logic       r_rs;
      logic [7:0] r_d;
      logic [8:0] fq [4];

      reset = 1'b1; cmd_valid = 1'b0; cmd_rs = 1'b0; cmd_data = 8'h00;
      repeat (3) @(posedge clock);
      #1;
      check_reset_outputs();
      @(negedge clock);
      reset = 1'b0;

`ifdef LCD_CMD_FIFO_EN
      base = obs_q.size();
      for (int p = 0; p < 4; p++) begin
         fq[p] = {1'($urandom_range(0, 1)), 8'($urandom)};
         cmd_valid = 1'b1; cmd_rs = fq[p][8]; cmd_data = fq[p][7:0];
         @(posedge clock); #1;
      end
      cmd_valid = 1'b0;
      check("fifo_full_ready", cmd_ready, 0);
      found = 0;
      for (int i = 0; i < 5000; i++) begin
         @(posedge clock); #1;
         if (!busy) begin found = 1; break; end
      end
      check("fifo_busy_falls", found, 1);
      check("fifo_init_done", init_done, 1);
      check("fifo_pulses", obs_q.size() - base, 20);
      for (int j = 0; j < 12; j++)
         check($sformatf("fifo_init_nib%0d", j), obs_q[base + j], {1'b0, INIT_NIBS[j]});
      for (int p = 0; p < 4; p++) begin
         check($sformatf("fifo_hi%0d", p), obs_q[base + 12 + 2 * p], {fq[p][8], fq[p][7:4]});
         check($sformatf("fifo_lo%0d", p), obs_q[base + 13 + 2 * p], {fq[p][8], fq[p][3:0]});
      end
      check("fifo_db_stable", stab_bad, 0);
`else
      check_init();

      do_byte(1'b1, 8'h41);
      do_byte(1'b0, 8'h01);
      do_byte(1'b1, 8'h01);
      do_byte(1'b0, 8'h02);
      do_byte(1'b0, 8'h03);

      for (int n = 0; n < 8; n++) begin
         r_rs = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       r_d = 8'h01;
            1:       r_d = 8'h02;
            default: r_d = 8'($urandom);
         endcase
         do_byte(r_rs, r_d);
      end

      // Requester holds cmd_valid across two bytes.
      base = obs_q.size();
      send_byte(1'b1, 8'h48, 1'b1);
      send_byte(1'b1, 8'h49, 1'b0);
      wait_ready(k);
      repeat (30) @(posedge clock);
      #1;
      check("held_pulses", obs_q.size() - base, 4);
      check("held_n0", obs_q[base],     5'h14);
      check("held_n1", obs_q[base + 1], 5'h18);
      check("held_n2", obs_q[base + 2], 5'h14);
      check("held_n3", obs_q[base + 3], 5'h19);

      // Reset while E is high mid data byte.
      send_byte(1'b1, 8'h5A, 1'b0);
      found = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (lcd_e) begin found = 1; break; end
      end
      check("e_high_seen", found, 1);
      reset = 1'b1;
      @(posedge clock); #1;
      check_reset_outputs();
      @(negedge clock);
      reset = 1'b0;
      check_init();
      do_byte(1'b1, 8'h42);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
